// File: rtl/mealy_seq_pkg.sv
// Shared types and constants for the 1101 serial sequence detector.
package mealy_seq_pkg;

    localparam int STATE_W = 2;

    // Each state names the longest useful prefix of 1101 seen so far.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'b00,
        S_1    = 2'b01,
        S_11   = 2'b10,
        S_110  = 2'b11
    } state_t;

    // Pattern being searched for, first-arrived bit in the MSB.
    localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/mealy_seq_detector_if.sv
// Serial stream interface: one data bit in, one detect flag out.
interface mealy_seq_detector_if;

    logic in_seq;
    logic seq_detected;

    // The stream source drives bits and observes detections.
    modport master (
        output in_seq,
        input  seq_detected
    );

    // The detector consumes bits and reports detections.
    modport slave (
        input  in_seq,
        output seq_detected
    );

endinterface

// File: rtl/mealy_seq_detector.sv
// Mealy detector for the serial pattern 1101 (first-arrived bit first).
// The detect flag is combinational and rises in the same cycle as the final 1.
module mealy_seq_detector
    import mealy_seq_pkg::*;
#(
    parameter bit OVERLAP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    mealy_seq_detector_if.slave  seq_if
);

    state_t state_reg;
    state_t state_next;

    // Next-state logic; the trailing 1 of a match seeds the next one only with OVERLAP.
    always_comb begin
        state_next = S_IDLE;
        case (state_reg)
            S_IDLE:  state_next = seq_if.in_seq ? S_1   : S_IDLE;
            S_1:     state_next = seq_if.in_seq ? S_11  : S_IDLE;
            S_11:    state_next = seq_if.in_seq ? S_11  : S_110;
            S_110: begin
                if (seq_if.in_seq) begin
                    state_next = OVERLAP ? S_1 : S_IDLE;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register; rst low at an edge discards any partial match.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Gating with rst keeps the output low during reset even if the state is unknown.
    assign seq_if.seq_detected = rst & (state_reg == S_110) & seq_if.in_seq;

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Directed bench for mealy_seq_detector, exercising both OVERLAP settings side by side.
module tb_mealy_seq_detector;
    import mealy_seq_pkg::*;

    logic clk;
    logic rst;

    int checks_cnt;
    int errors_cnt;

    mealy_seq_detector_if if_ov ();
    mealy_seq_detector_if if_no ();

    mealy_seq_detector #(.OVERLAP(1'b1)) u_dut_ov (
        .clk    (clk),
        .rst    (rst),
        .seq_if (if_ov)
    );

    mealy_seq_detector #(.OVERLAP(1'b0)) u_dut_no (
        .clk    (clk),
        .rst    (rst),
        .seq_if (if_no)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports any mismatch.
    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one bit for a cycle, checks both detectors before the edge, then clocks it in.
    task automatic step(input string tag, input int idx, input logic r, input logic b,
                        input logic exp_ov, input logic exp_no);
        rst          = r;
        if_ov.in_seq = b;
        if_no.in_seq = b;
        #1;
        $display("%s[%0d] rst=%b in=%b det_ov=%b det_no=%b", tag, idx, r, b,
                 if_ov.seq_detected, if_no.seq_detected);
        check_eq($sformatf("%s_ov[%0d]", tag, idx), {3'b0, if_ov.seq_detected}, {3'b0, exp_ov});
        check_eq($sformatf("%s_no[%0d]", tag, idx), {3'b0, if_no.seq_detected}, {3'b0, exp_no});
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        step("flush", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [0:28] stream;
    logic [0:6]  ovl;
    logic [0:7]  run;
    logic        e;
    logic        e_ov;
    logic        e_no;

    initial begin
        checks_cnt   = 0;
        errors_cnt   = 0;
        rst          = 1'b0;
        if_ov.in_seq = 1'b1;
        if_no.in_seq = 1'b1;
        stream       = 29'b11110100110110011101111010000;
        ovl          = 7'b1101101;
        run          = 8'b11111101;
        $display("pattern %b", PATTERN);

        // Output must be low during reset before any clock edge.
        #1;
        check_eq("pre_edge_ov", {3'b0, if_ov.seq_detected}, 4'h0);
        check_eq("pre_edge_no", {3'b0, if_no.seq_detected}, 4'h0);
        @(posedge clk);
        #1;
        flush();

        // Main stream: pulses on bits 5, 11, 19, 24 for both settings.
        for (int i = 0; i < 29; i++) begin
            e = (i == 5) || (i == 11) || (i == 19) || (i == 24);
            step("stream", i, 1'b1, stream[i], e, e);
        end
        flush();

        // Overlap: 1101101 pulses on 3 and 6 with overlap, only 3 without.
        for (int i = 0; i < 7; i++) begin
            e_ov = (i == 3) || (i == 6);
            e_no = (i == 3);
            step("overlap", i, 1'b1, ovl[i], e_ov, e_no);
        end
        flush();

        // Long run of ones then 01: a single pulse on the final bit.
        for (int i = 0; i < 8; i++) begin
            e = (i == 7);
            step("run", i, 1'b1, run[i], e, e);
        end
        flush();

        // Same stream held in reset: never detects, state parked in idle.
        for (int i = 0; i < 29; i++) begin
            step("in_rst", i, 1'b0, stream[i], 1'b0, 1'b0);
        end
        check_eq("rst_state_ov", 4'(u_dut_ov.state_reg), 4'(S_IDLE));
        check_eq("rst_state_no", 4'(u_dut_no.state_reg), 4'(S_IDLE));

        // Mid-match reset: 110, reset with in=1, then 1 (no pulse), then 101 (pulse).
        step("midrst", 0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("midrst", 1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("midrst", 2, 1'b1, 1'b0, 1'b0, 1'b0);
        step("midrst", 3, 1'b0, 1'b1, 1'b0, 1'b0);
        step("midrst", 4, 1'b1, 1'b1, 1'b0, 1'b0);
        step("midrst", 5, 1'b1, 1'b1, 1'b0, 1'b0);
        step("midrst", 6, 1'b1, 1'b0, 1'b0, 1'b0);
        step("midrst", 7, 1'b1, 1'b1, 1'b1, 1'b1);
        flush();

        // Combinational path: reach S_110, then toggle in_seq within one cycle.
        step("comb", 0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("comb", 1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("comb", 2, 1'b1, 1'b0, 1'b0, 1'b0);
        rst          = 1'b1;
        if_ov.in_seq = 1'b0;
        if_no.in_seq = 1'b0;
        #1;
        check_eq("comb_low_ov", {3'b0, if_ov.seq_detected}, 4'h0);
        check_eq("comb_low_no", {3'b0, if_no.seq_detected}, 4'h0);
        if_ov.in_seq = 1'b1;
        if_no.in_seq = 1'b1;
        #1;
        $display("comb toggle det_ov=%b det_no=%b", if_ov.seq_detected, if_no.seq_detected);
        check_eq("comb_high_ov", {3'b0, if_ov.seq_detected}, 4'h1);
        check_eq("comb_high_no", {3'b0, if_no.seq_detected}, 4'h1);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
